// File: rtl/up_clock_edge_filtered_if.sv
// Purpose: bundles the per-channel monitor inputs and the filtered level/edge/period results.
// Latency: none; this is wiring only.
// Backpressure: none; the results are single-cycle pulses and held registers with no ready signal.
// Ports: enable, test_clk[NUM_CH] go in; level, rising_edge, falling_edge, period_valid[NUM_CH]
//        and period[NUM_CH*CNT_W] (channel i at [i*CNT_W +: CNT_W]) come out.
interface up_clock_edge_filtered_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    logic                      enable;
    logic [NUM_CH-1:0]         test_clk;
    logic [NUM_CH-1:0]         level;
    logic [NUM_CH-1:0]         rising_edge;
    logic [NUM_CH-1:0]         falling_edge;
    logic [NUM_CH*CNT_W-1:0]   period;
    logic [NUM_CH-1:0]         period_valid;

    // Stimulus side: drives the monitored signals and reads the results.
    modport master (
        output enable, test_clk,
        input  level, rising_edge, falling_edge, period, period_valid
    );

    // Design side.
    modport slave (
        input  enable, test_clk,
        output level, rising_edge, falling_edge, period, period_valid
    );
endinterface

// File: rtl/up_clock_edge_filtered.sv
// Purpose: per channel, synchronises, glitch-filters and edge-detects an async slow clock, and measures its rise-to-rise period.
// Latency: a stable input change reaches level/edge pulses SYNC_STAGES+FILTER_CYCLES-1 edges after it is first sampled.
// Backpressure: none; pulses are one cycle wide and are lost if not sampled.
// Ports: clk (rising edge), reset (async, active low), bus (slave modport: enable, test_clk in;
//        level, rising_edge, falling_edge, period, period_valid out).
module up_clock_edge_filtered #(
    parameter int NUM_CH        = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_W         = 16,
    parameter bit INIT_LEVEL    = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    up_clock_edge_filtered_if.slave   bus
);

    // A one-cycle filter still needs a 1-bit counter so the arrays stay well formed.
    localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [FW-1:0]    FILT_LAST = FW'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] sync_d [SYNC_STAGES];
    logic [NUM_CH-1:0] level_q, level_d;
    logic [NUM_CH-1:0] rise_q, rise_d;
    logic [NUM_CH-1:0] fall_q, fall_d;
    logic [NUM_CH-1:0] pv_q, pv_d;
    logic [NUM_CH-1:0] seen_q, seen_d;
    logic [FW-1:0]     filt_q [NUM_CH];
    logic [FW-1:0]     filt_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];
    logic [CNT_W-1:0]  per_q  [NUM_CH];
    logic [CNT_W-1:0]  per_d  [NUM_CH];
    logic [NUM_CH-1:0] sync_out;
    logic [NUM_CH-1:0] accept;

    always_comb begin
        sync_d[0] = bus.test_clk;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        pv_d    = '0;
        seen_d  = seen_q;
        accept  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            filt_d[i] = filt_q[i];
            cnt_d[i]  = cnt_q[i];
            per_d[i]  = per_q[i];

            // Stability filter: any return to the current level drops the pending change.
            if (sync_out[i] == level_q[i]) begin
                filt_d[i] = '0;
            end else if (filt_q[i] == FILT_LAST) begin
                accept[i]  = 1'b1;
                level_d[i] = sync_out[i];
                filt_d[i]  = '0;
            end else begin
                filt_d[i] = filt_q[i] + 1'b1;
            end

            // On accept the new level equals sync_out, so it tells rise from fall.
            rise_d[i] = accept[i] &  sync_out[i] & bus.enable;
            fall_d[i] = accept[i] & ~sync_out[i] & bus.enable;

            // Period counter restarts at 1 on a rise so it counts edges between rises.
            if (!bus.enable) begin
                cnt_d[i]  = '0;
                seen_d[i] = 1'b0;
            end else if (accept[i] && sync_out[i]) begin
                if (seen_q[i]) begin
                    per_d[i] = cnt_q[i];
                    pv_d[i]  = 1'b1;
                end
                cnt_d[i]  = CNT_W'(1);
                seen_d[i] = 1'b1;
            end else if (cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= {NUM_CH{INIT_LEVEL}};
            end
            level_q <= {NUM_CH{INIT_LEVEL}};
            rise_q  <= '0;
            fall_q  <= '0;
            pv_q    <= '0;
            seen_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                filt_q[i] <= '0;
                cnt_q[i]  <= '0;
                per_q[i]  <= '0;
            end
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            pv_q    <= pv_d;
            seen_q  <= seen_d;
            for (int i = 0; i < NUM_CH; i++) begin
                filt_q[i] <= filt_d[i];
                cnt_q[i]  <= cnt_d[i];
                per_q[i]  <= per_d[i];
            end
        end
    end

    assign bus.level        = level_q;
    assign bus.rising_edge  = rise_q;
    assign bus.falling_edge = fall_q;
    assign bus.period_valid = pv_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_period
        assign bus.period[g*CNT_W +: CNT_W] = per_q[g];
    end

endmodule

// File: tb/tb_up_clock_edge_filtered.sv
module tb_up_clock_edge_filtered;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    up_clock_edge_filtered_if #(.NUM_CH(4), .CNT_W(16)) b0 ();
    up_clock_edge_filtered_if #(.NUM_CH(4), .CNT_W(4))  b1 ();

    up_clock_edge_filtered d0 (.clk(clk), .reset(reset), .bus(b0));
    up_clock_edge_filtered #(.CNT_W(4)) d1 (.clk(clk), .reset(reset), .bus(b1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        b0.enable = 1'b1; b0.test_clk = 4'b0000;
        b1.enable = 1'b1; b1.test_clk = 4'b0000;

        // Reset state
        step(); step();
        chk("rst_level", b0.level, 4'b0000);
        chk("rst_rise",  b0.rising_edge, 4'b0000);
        chk("rst_fall",  b0.falling_edge, 4'b0000);
        chk("rst_pv",    b0.period_valid, 4'b0000);
        chk("rst_period", b0.period, 64'h0);
        chk("rst_period_sat", b1.period, 64'h0);
        reset = 1'b1;
        step(); step(); step();
        chk("idle_level", b0.level, 4'b0000);

        // ch0 0->1: pulse at E5, exactly one cycle
        b0.test_clk[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t1_rise",  b0.rising_edge, (k == 5) ? 4'b0001 : 4'b0000);
            chk("t1_fall",  b0.falling_edge, 4'b0000);
            chk("t1_level", b0.level, (k >= 5) ? 4'b0001 : 4'b0000);
        end

        // ch1 glitches of 1..3 cycles are rejected
        for (int w = 1; w <= 3; w++) begin
            b0.test_clk[1] = 1'b1;
            for (int k = 0; k < w; k++) step();
            b0.test_clk[1] = 1'b0;
            for (int k = 0; k < 10; k++) begin
                step();
                chk("t2_glitch_rise",  b0.rising_edge, 4'b0000);
                chk("t2_glitch_level", b0.level, 4'b0001);
            end
        end
        // 4-cycle pulse: rise at E5, fall at E9
        b0.test_clk[1] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 4) b0.test_clk[1] = 1'b0;
            step();
            chk("t2_rise", b0.rising_edge,  (k == 5) ? 4'b0010 : 4'b0000);
            chk("t2_fall", b0.falling_edge, (k == 9) ? 4'b0010 : 4'b0000);
        end

        // ch2 square wave, period 20
        for (int t = 0; t < 70; t++) begin
            b0.test_clk[2] = ((t % 20) < 10);
            step();
            chk("t3_rise", b0.rising_edge,  ((t % 20) == 5)  ? 4'b0100 : 4'b0000);
            chk("t3_fall", b0.falling_edge, ((t % 20) == 15) ? 4'b0100 : 4'b0000);
            chk("t3_pv",   b0.period_valid, (t == 25 || t == 45 || t == 65) ? 4'b0100 : 4'b0000);
            if (t >= 25) chk("t3_period", b0.period[47:32], 16'd20);
        end

        // CNT_W=4 instance: rises 30 apart saturate to 15
        for (int t = 0; t < 66; t++) begin
            b1.test_clk[3] = ((t % 30) < 5);
            step();
            chk("t4_rise",   b1.rising_edge,  ((t % 30) == 5) ? 4'b1000 : 4'b0000);
            chk("t4_pv",     b1.period_valid, (t == 35 || t == 65) ? 4'b1000 : 4'b0000);
            chk("t4_period", b1.period, (t >= 35) ? 64'hF000 : 64'h0);
        end

        // Settle d0 low, then a disabled cycle clears the seen flags
        b0.test_clk = 4'b0000;
        for (int k = 0; k < 8; k++) step();
        b0.enable = 1'b0;
        step();
        b0.enable = 1'b1;

        // Simultaneous rise on all channels
        b0.test_clk = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t5_rise", b0.rising_edge, (k == 5) ? 4'b1111 : 4'b0000);
            chk("t5_pv",   b0.period_valid, 4'b0000);
        end
        chk("t5_level",  b0.level, 4'b1111);
        chk("t5_period", b0.period, 64'h0000_0014_0000_0000);

        // Disabled: level tracks, no pulses, period holds
        b0.enable = 1'b0;
        b0.test_clk = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t6_fall", b0.falling_edge, 4'b0000);
            chk("t6_pv",   b0.period_valid, 4'b0000);
        end
        chk("t6_level_lo", b0.level, 4'b0000);
        b0.test_clk = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t6_rise", b0.rising_edge, 4'b0000);
        end
        chk("t6_level_hi", b0.level, 4'b1111);
        b0.test_clk = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t6_fall2", b0.falling_edge, 4'b0000);
        end
        chk("t6_level_lo2", b0.level, 4'b0000);
        chk("t6_period_hold", b0.period, 64'h0000_0014_0000_0000);

        // Re-enable: first rise gives no period_valid, later rises report 20
        b0.enable = 1'b1;
        for (int t = 0; t < 46; t++) begin
            b0.test_clk = ((t % 20) < 10) ? 4'b1111 : 4'b0000;
            step();
            chk("t7_rise", b0.rising_edge,  ((t % 20) == 5)  ? 4'b1111 : 4'b0000);
            chk("t7_fall", b0.falling_edge, ((t % 20) == 15) ? 4'b1111 : 4'b0000);
            chk("t7_pv",   b0.period_valid, (t == 25 || t == 45) ? 4'b1111 : 4'b0000);
        end
        chk("t7_period", b0.period, 64'h0014_0014_0014_0014);

        // Reset mid-filter with ch0 high
        b0.test_clk = 4'b0000;
        for (int k = 0; k < 8; k++) step();
        b0.test_clk = 4'b0001;
        step(); step(); step();
        reset = 1'b0;
        #1;
        chk("t8_rst_level",  b0.level, 4'b0000);
        chk("t8_rst_rise",   b0.rising_edge, 4'b0000);
        chk("t8_rst_fall",   b0.falling_edge, 4'b0000);
        chk("t8_rst_pv",     b0.period_valid, 4'b0000);
        chk("t8_rst_period", b0.period, 64'h0);
        step();
        chk("t8_rst_hold", b0.level, 4'b0000);
        reset = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("t8_rise",  b0.rising_edge, (k == 5) ? 4'b0001 : 4'b0000);
            chk("t8_fall",  b0.falling_edge, 4'b0000);
            chk("t8_level", b0.level, (k >= 5) ? 4'b0001 : 4'b0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
